mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported synchronous instruction/data memory between the fetch stage
//  (instruction reads at the predicted/redirected PC) and the execute stage (LD/ST).
//  Issues at most one access per cycle. Tracks which requester owns the in-flight read.
//  Generates the fetch stall and squashes fetch read data on a branch redirect.
// PARAMETERS
//  ADDR_W      16  memory address width; PC is zero-extended into it
//  DATA_W      16  memory word / instruction width
//  STARVE_MAX  3   consecutive denied fetch cycles before fetch wins one cycle (legal 1..15)
// PORTS
//  clk           in   1       clock
//  reset         in   1       synchronous, active-high
//  i_if_req      in   1       fetch read request; held until granted
//  i_if_addr     in   ADDR_W  fetch address
//  i_flush       in   1       branch redirect: cancels fetch grant and in-flight fetch data
//  o_if_gnt      out  1       fetch access issued this cycle
//  o_if_rvalid   out  1       o_rdata is the fetch word
//  i_d_req       in   1       data request; held until granted
//  i_d_we        in   1       1=store, 0=load
//  i_d_addr      in   ADDR_W  data address
//  i_d_wdata     in   DATA_W  store data
//  o_d_gnt       out  1       data access issued this cycle
//  o_d_rvalid    out  1       o_rdata is the load word
//  o_rdata       out  DATA_W  = i_mem_rdata (shared return bus)
//  o_mem_addr    out  ADDR_W  memory address
//  o_mem_we      out  1       memory write enable
//  o_mem_wdata   out  DATA_W  memory write data
//  i_mem_rdata   in   DATA_W  memory read data; valid 1 cycle after a read is issued
//  o_stall_fetch out  1       i_if_req & ~o_if_gnt
// BEHAVIOUR
//  Grants are combinational from the current requests and state; read return latency is 1 cycle.
//  Arbitration per cycle:
//   - d_req and (no if_req, or starve_cnt<STARVE_MAX) -> d granted.
//   - if_req and ~i_flush and (no d_req, or starve_cnt==STARVE_MAX) -> fetch granted.
//   - i_flush forces o_if_gnt=0. If fetch was selected, the port idles or serves d_req instead.
//   - No grant: o_mem_addr=0, o_mem_we=0, o_mem_wdata=0.
//  Starve counter:
//   - +1 (saturating at STARVE_MAX) when if_req & ~i_flush & d granted.
//   - Clear on fetch grant, when ~if_req, or on i_flush.
//  Read-owner FSM (rd_owner, registered):
//   - RD_NONE/RD_IF/RD_D. Next state = RD_IF if fetch granted; RD_D if d granted with ~i_d_we; else RD_NONE.
//   - Any state can move to any state each cycle, so back-to-back reads are pipelined with no bubble.
//  Return valids:
//   - o_if_rvalid = (rd_owner==RD_IF) & ~i_flush. A flush in the return cycle squashes the word.
//   - o_d_rvalid = (rd_owner==RD_D).
//   - Stores produce no rvalid.
//  Fetch squash: a flush in the grant cycle clears the grant, so no fetch rvalid follows the next cycle.
//  Reset: rd_owner=RD_NONE and starve_cnt=0. While reset is high, all grants, rvalids, o_mem_we and
//   o_stall_fetch are 0 and o_mem_addr/o_mem_wdata are 0. A read in flight at reset never returns valid.
//  Simultaneous load+fetch with counter saturated: fetch wins, d stays pending.
//   Next cycle d wins; d is never denied two cycles in a row.
// STRUCTURE
//  pipe_pkg gets: typedef enum logic [1:0] {RD_NONE, RD_IF, RD_D} rd_owner_e; default ADDR_W/DATA_W.
//  Sub-module mem_arb_starve_cnt (saturating counter + at_max flag, param MAX).
//  The grant mux, FSM and valid logic live in the top module.
// TESTING
//  1 Fetch-only read addr 0x0005, mem holds 0x1234 -> if_gnt=1 same cycle, mem_addr=0x0005;
//    next cycle if_rvalid=1, o_rdata=0x1234, d_rvalid=0.
//  2 if_req and d loads held 6 cycles, STARVE_MAX=3 -> grants D,D,D,IF,D,D;
//    o_stall_fetch high in cycles 0-2 and 4-5.
//  3 Store addr 0x0020 wdata 0xBEEF -> mem_we=1, mem_wdata=0xBEEF, d_gnt=1; d_rvalid stays 0;
//    a load of 0x0020 next cycle returns 0xBEEF.
//  4 Fetch granted at cycle N, i_flush=1 at N+1 -> if_rvalid=0 at N+1;
//    flush with if_req and no d_req -> if_gnt=0, mem_we=0, stall_fetch=1.
//  5 Load granted, reset asserted next cycle -> d_rvalid=0; after release starve_cnt=0 and
//    fetch-only request granted immediately.
//  6 Back-to-back reads fetch 0x01, load 0x40, fetch 0x02 -> owners IF,D,IF returned in order, no idle cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 16;
    localparam int STARVE_MAX_DEF = 3;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_IF,
        RD_D
    } rd_owner_e;

    function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] max);
        return (val >= max) ? max : val + 4'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter, bundled with master/slave views.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              i_flush;
    logic              o_if_gnt;
    logic              o_if_rvalid;
    logic              i_d_req;
    logic              i_d_we;
    logic [ADDR_W-1:0] i_d_addr;
    logic [DATA_W-1:0] i_d_wdata;
    logic              o_d_gnt;
    logic              o_d_rvalid;
    logic [DATA_W-1:0] o_rdata;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_we;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_stall_fetch;

    // Arbiter side
    modport slave (
        input  i_if_req, i_if_addr, i_flush, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_mem_rdata,
        output o_if_gnt, o_if_rvalid, o_d_gnt, o_d_rvalid, o_rdata,
        output o_mem_addr, o_mem_we, o_mem_wdata, o_stall_fetch
    );

    // Requesters plus memory model side
    modport master (
        output i_if_req, i_if_addr, i_flush, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_mem_rdata,
        input  o_if_gnt, o_if_rvalid, o_d_gnt, o_d_rvalid, o_rdata,
        input  o_mem_addr, o_mem_we, o_mem_wdata, o_stall_fetch
    );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive cycles fetch was denied; at_max lets fetch win one cycle.
module mem_arb_starve_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);
    localparam logic [3:0] MAX_L = 4'(MAX);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (inc) begin
            cnt <= sat_inc(cnt, MAX_L);
        end
    end

    assign at_max = (cnt == MAX_L);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between fetch and LD/ST; tracks the owner of the
// in-flight read so the 1-cycle return is steered to the right requester.
//
//  state   | meaning
//  RD_NONE | no read in flight, return bus carries nothing
//  RD_IF   | fetch read issued last cycle, word returns now
//  RD_D    | load issued last cycle, word returns now
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [DATA_W-1:0] DATA_ZERO = '0;

    rd_owner_e rd_owner;
    rd_owner_e rd_owner_nxt;
    logic      starve_at_max;
    logic      if_gnt;
    logic      d_gnt;

    mem_arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (if_gnt | ~bus.i_if_req | bus.i_flush),
        .inc    (bus.i_if_req & ~bus.i_flush & d_gnt),
        .at_max (starve_at_max)
    );

    // A flushed fetch never takes the slot, so a pending data request gets it instead.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset) begin
            if_gnt = bus.i_if_req & ~bus.i_flush & (~bus.i_d_req | starve_at_max);
            d_gnt  = bus.i_d_req & ~if_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner <= RD_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    always_comb begin
        rd_owner_nxt = RD_NONE;
        if (if_gnt) begin
            rd_owner_nxt = RD_IF;
        end else if (d_gnt && !bus.i_d_we) begin
            rd_owner_nxt = RD_D;
        end
    end

    always_comb begin
        bus.o_mem_addr  = ADDR_ZERO;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_wdata = DATA_ZERO;
        if (if_gnt) begin
            bus.o_mem_addr = bus.i_if_addr;
        end else if (d_gnt) begin
            bus.o_mem_addr  = bus.i_d_addr;
            bus.o_mem_we    = bus.i_d_we;
            bus.o_mem_wdata = bus.i_d_wdata;
        end
    end

    assign bus.o_if_gnt      = if_gnt;
    assign bus.o_d_gnt       = d_gnt;
    assign bus.o_if_rvalid   = ~reset & (rd_owner == RD_IF) & ~bus.i_flush;
    assign bus.o_d_rvalid    = ~reset & (rd_owner == RD_D);
    assign bus.o_rdata       = bus.i_mem_rdata;
    assign bus.o_stall_fetch = ~reset & bus.i_if_req & ~if_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a per-cycle reference model predicts grants and
// queues the expected read return, which is popped and compared one cycle later.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int SMAX = 3;

    typedef struct {
        rd_owner_e   owner;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic reset;
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.o_mem_we) mem[bus.o_mem_addr[7:0]] <= bus.o_mem_wdata;
        bus.i_mem_rdata <= mem[bus.o_mem_addr[7:0]];
    end

    int          n_vec  = 0;
    int          n_miss = 0;
    exp_t        sb[$];
    logic [15:0] ref_mem [0:255];
    int          m_starve = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic ifr, input logic [15:0] ifa, input logic fl,
                        input logic dr, input logic dwe, input logic [15:0] da,
                        input logic [15:0] dwd);
        logic        at_max, e_if, e_d, e_we, e_stall, e_ifrv, e_drv;
        logic [15:0] e_addr, e_wd;
        exp_t        ex, nx;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.i_if_req  = ifr;
        bus.i_if_addr = ifa;
        bus.i_flush   = fl;
        bus.i_d_req   = dr;
        bus.i_d_we    = dwe;
        bus.i_d_addr  = da;
        bus.i_d_wdata = dwd;
        @(negedge clk);
        at_max  = (m_starve == SMAX);
        e_if    = ~rst & ifr & ~fl & (~dr | at_max);
        e_d     = ~rst & dr & ~e_if;
        e_addr  = e_if ? ifa : (e_d ? da : 16'h0);
        e_we    = e_d & dwe;
        e_wd    = e_d ? dwd : 16'h0;
        e_stall = ~rst & ifr & ~e_if;
        check_val("if_gnt", 32'(bus.o_if_gnt), 32'(e_if));
        check_val("d_gnt", 32'(bus.o_d_gnt), 32'(e_d));
        check_val("mem_addr", 32'(bus.o_mem_addr), 32'(e_addr));
        check_val("mem_we", 32'(bus.o_mem_we), 32'(e_we));
        check_val("mem_wdata", 32'(bus.o_mem_wdata), 32'(e_wd));
        check_val("stall_fetch", 32'(bus.o_stall_fetch), 32'(e_stall));
        if (sb.size() == 0) begin
            check_val("sb_underflow", 32'(sb.size()), 32'd1);
            ex.owner = RD_NONE;
            ex.data  = 16'h0;
        end else begin
            ex = sb.pop_front();
        end
        e_ifrv = (ex.owner == RD_IF) & ~fl & ~rst;
        e_drv  = (ex.owner == RD_D) & ~rst;
        check_val("if_rvalid", 32'(bus.o_if_rvalid), 32'(e_ifrv));
        check_val("d_rvalid", 32'(bus.o_d_rvalid), 32'(e_drv));
        if (e_ifrv || e_drv) check_val("rdata", 32'(bus.o_rdata), 32'(ex.data));
        if (e_we) ref_mem[da[7:0]] = dwd;
        nx.owner = rst ? RD_NONE : (e_if ? RD_IF : ((e_d && !dwe) ? RD_D : RD_NONE));
        nx.data  = ref_mem[e_addr[7:0]];
        sb.push_back(nx);
        if (rst || e_if || !ifr || fl) m_starve = 0;
        else if (e_d && m_starve < SMAX) m_starve++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    logic [5:0] g_pat, s_pat;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
        reset = 1'b1;
        bus.i_if_req = 1'b0; bus.i_if_addr = '0; bus.i_flush = 1'b0;
        bus.i_d_req = 1'b0; bus.i_d_we = 1'b0; bus.i_d_addr = '0; bus.i_d_wdata = '0;
        sb.push_back('{RD_NONE, 16'h0});

        // reset with requests pending: everything must stay quiet
        step(1'b1, 1'b1, 16'h3, 1'b0, 1'b1, 1'b1, 16'h3, 16'h5555);
        check_val("rst_if_gnt", 32'(bus.o_if_gnt), 32'd0);
        check_val("rst_mem_we", 32'(bus.o_mem_we), 32'd0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

        // preload low memory through the data store path
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'(i), 16'h1000 + 16'(i));
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h1234);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0001, 16'hA001);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0002, 16'hA002);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'hD040);

        // fetch-only read of 0x0005
        step(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        check_val("t1_if_gnt", 32'(bus.o_if_gnt), 32'd1);
        check_val("t1_mem_addr", 32'(bus.o_mem_addr), 32'h0005);
        idle();
        check_val("t1_if_rvalid", 32'(bus.o_if_rvalid), 32'd1);
        check_val("t1_rdata", 32'(bus.o_rdata), 32'h1234);
        check_val("t1_d_rvalid", 32'(bus.o_d_rvalid), 32'd0);

        // starvation: fetch and loads held together for 6 cycles
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
            g_pat[c] = bus.o_if_gnt;
            s_pat[c] = bus.o_stall_fetch;
        end
        check_val("t2_if_gnt_pattern", 32'(g_pat), 32'b001000);
        check_val("t2_stall_pattern", 32'(s_pat), 32'b110111);
        idle();

        // store then load the same address
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'hBEEF);
        check_val("t3_mem_we", 32'(bus.o_mem_we), 32'd1);
        check_val("t3_mem_wdata", 32'(bus.o_mem_wdata), 32'hBEEF);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
        check_val("t3_store_no_rvalid", 32'(bus.o_d_rvalid), 32'd0);
        idle();
        check_val("t3_load_rvalid", 32'(bus.o_d_rvalid), 32'd1);
        check_val("t3_load_rdata", 32'(bus.o_rdata), 32'hBEEF);

        // flush in the return cycle, then flush in the grant cycle
        step(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        check_val("t4_squash_rvalid", 32'(bus.o_if_rvalid), 32'd0);
        check_val("t4_flush_if_gnt", 32'(bus.o_if_gnt), 32'd0);
        check_val("t4_flush_stall", 32'(bus.o_stall_fetch), 32'd1);
        idle();
        check_val("t4_no_late_rvalid", 32'(bus.o_if_rvalid), 32'd0);

        // load in flight across a reset
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        check_val("t5_d_rvalid", 32'(bus.o_d_rvalid), 32'd0);
        step(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        check_val("t5_if_gnt", 32'(bus.o_if_gnt), 32'd1);
        idle();

        // back-to-back reads IF, D, IF
        step(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
        check_val("t6_ret1", 32'({bus.o_if_rvalid, bus.o_rdata}), 32'h1A001);
        step(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        check_val("t6_ret2", 32'({bus.o_d_rvalid, bus.o_rdata}), 32'h1D040);
        idle();
        check_val("t6_ret3", 32'({bus.o_if_rvalid, bus.o_rdata}), 32'h1A002);

        // random traffic against the reference model
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                 ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 16'($urandom_range(0, 15)), 16'($urandom));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
